// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: mdop codes, default latencies, decode mapping.
// MDU_MADD_EN adds the MADD/MADDU accumulate ops.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10
    } mdop_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1a;
    localparam logic [5:0] FN_DIVU     = 6'h1b;
    localparam logic [5:0] FN_MADD     = 6'h00;
    localparam logic [5:0] FN_MADDU    = 6'h01;

    function automatic logic [3:0] decode_mdop(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic [3:0] r;
        r = MD_NONE;
        if (op == OP_SPECIAL) begin
            case (fn)
                FN_MFHI:  r = MD_MFHI;
                FN_MTHI:  r = MD_MTHI;
                FN_MFLO:  r = MD_MFLO;
                FN_MTLO:  r = MD_MTLO;
                FN_MULT:  r = MD_MULT;
                FN_MULTU: r = MD_MULTU;
                FN_DIV:   r = MD_DIV;
                FN_DIVU:  r = MD_DIVU;
                default:  r = MD_NONE;
            endcase
        end else if (op == OP_SPECIAL2) begin
            case (fn)
                FN_MADD:  r = MD_MADD;
                FN_MADDU: r = MD_MADDU;
                default:  r = MD_NONE;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) ||
            (op == MD_DIV)  || (op == MD_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide/accumulate datapath for the MDU.
// MDU_MADD_EN adds the HI/LO accumulate inputs and MADD/MADDU.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
`ifdef MDU_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    output hilo_t       o_res,
    output logic        o_we
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_aneg;
    logic        w_bneg;
    logic        w_bz;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [31:0] w_bsafe;
    logic [31:0] w_bmsafe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_mq;
    logic [31:0] w_mr;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    // Sign-extended 64x64 product truncated to 64 bits is the signed product.
    assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod = {32'b0, i_a} * {32'b0, i_b};

    assign w_aneg   = i_a[31];
    assign w_bneg   = i_b[31];
    assign w_bz     = (i_b == 32'd0);
    assign w_amag   = w_aneg ? -i_a : i_a;
    assign w_bmag   = w_bneg ? -i_b : i_b;
    assign w_bsafe  = w_bz ? 32'd1 : i_b;
    assign w_bmsafe = w_bz ? 32'd1 : w_bmag;

    assign w_uq = i_a / w_bsafe;
    assign w_ur = i_a % w_bsafe;
    assign w_mq = w_amag / w_bmsafe;
    assign w_mr = w_amag % w_bmsafe;
    assign w_sq = (w_aneg ^ w_bneg) ? -w_mq : w_mq;
    assign w_sr = w_aneg ? -w_mr : w_mr;

    always_comb begin
        o_res = '0;
        o_we  = 1'b0;
        case (i_op)
            MD_MULT:  begin o_res = w_sprod;      o_we = 1'b1; end
            MD_MULTU: begin o_res = w_uprod;      o_we = 1'b1; end
            MD_DIV:   begin o_res = {w_sr, w_sq}; o_we = !w_bz; end
            MD_DIVU:  begin o_res = {w_ur, w_uq}; o_we = !w_bz; end
`ifdef MDU_MADD_EN
            MD_MADD:  begin o_res = {i_hi, i_lo} + w_sprod; o_we = 1'b1; end
            MD_MADDU: begin o_res = {i_hi, i_lo} + w_uprod; o_we = 1'b1; end
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning HI/LO with fixed-latency busy.
// MDU_MADD_EN enables MADD/MADDU accumulate.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    hilo_t         r_pend;
    logic          r_pwe;

    hilo_t w_res;
    logic  w_we;
    logic  w_busy;
    logic  w_start;
    logic  w_is_div;

    mdu_calc u_calc (
        .i_op  (mdop),
        .i_a   (a),
        .i_b   (b),
`ifdef MDU_MADD_EN
        .i_hi  (r_hi),
        .i_lo  (r_lo),
`endif
        .o_res (w_res),
        .o_we  (w_we)
    );

    assign w_busy   = (r_cnt != '0);
    assign w_start  = en && !w_busy && is_start(mdop);
    assign w_is_div = (mdop == MD_DIV) || (mdop == MD_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_pend <= '0;
            r_pwe  <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_pend <= w_res;
            r_pwe  <= w_we;
        end else if (w_busy) begin
            r_cnt <= r_cnt - CW'(1);
            // Final busy cycle: commit unless the op was a divide by zero.
            if (r_cnt == CW'(1) && r_pwe) begin
                r_hi <= r_pend.hi;
                r_lo <= r_pend.lo;
            end
        end else if (en) begin
            if (mdop == MD_MTHI) r_hi <= a;
            if (mdop == MD_MTLO) r_lo <= a;
        end
    end

    assign busy  = w_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = (mdop == MD_MFHI) ? r_hi : r_lo;

endmodule
